// File: rtl/mem_rep_agu.sv
// -----------------------------------------------------------------------------
// mem_rep_agu -- M-stage memory address sequencer
//
// Takes one instruction from the RRAG/M-stage operand latch, resolves the
// access size, applies the push pre-decrement on the stack channel, and then
// emits one registered access beat per cycle toward the d$ request port.
// A REP string op emits one beat per iteration. Every beat is checked against
// the per-channel segment limit, and a faulting beat ends the sequence.
//
// Handshake: a transfer happens on a rising clk edge where valid & ready are
// both high. A producer holding valid keeps its payload stable until ready is
// seen. Readiness never depends on the same-side valid.
// This applies to in_valid/in_ready and to out_valid/out_ready alike.
//
// Ports:
//   clk        stage clock
//   clr        asynchronous active-high reset
//   in_valid   instruction presented          in_ready   accepted this cycle
//   opsize     operand size code (0..3)       size_ovr   one-hot size override
//   is_rep     REP string op                  rep_cnt    iteration count
//   dir        1 = step addresses downward    is_push    pre-decrement stack ch
//   ch_addr    start address per channel      ch_rw      access type per channel
//   seg_max    highest legal byte per channel flush      synchronous cancel
//   out_valid  beat valid                     out_ready  d$ accepts beat
//   out_addr   beat address per channel       out_rw     latched ch_rw
//   out_size   resolved size code             out_last   final beat
//   out_iter   remaining iterations incl. this beat
//   exc_valid  beat has a segment-limit fault exc_ch     per-channel fault mask
//   busy       REP sequence in progress (decoded FSM state: 1 = RUN)
// -----------------------------------------------------------------------------
module mem_rep_agu #(
    parameter int NUM_CH = 2,
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic                     clk,
    input  logic                     clr,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [1:0]               opsize,
    input  logic [3:0]               size_ovr,
    input  logic                     is_rep,
    input  logic [CNT_W-1:0]         rep_cnt,
    input  logic                     dir,
    input  logic                     is_push,
    input  logic [NUM_CH*ADDR_W-1:0] ch_addr,
    input  logic [NUM_CH*2-1:0]      ch_rw,
    input  logic [NUM_CH*ADDR_W-1:0] seg_max,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [NUM_CH*ADDR_W-1:0] out_addr,
    output logic [NUM_CH*2-1:0]      out_rw,
    output logic [1:0]               out_size,
    output logic                     out_last,
    output logic [CNT_W-1:0]         out_iter,
    output logic                     exc_valid,
    output logic [NUM_CH-1:0]        exc_ch,
    output logic                     busy
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // The highest channel index carries the stack operand.
    localparam int STK = NUM_CH - 1;

    state_t state_q, state_d;

    // Per-instruction context captured at accept.
    logic                     dir_q;
    logic [ADDR_W-1:0]        bytes_q;
    logic [NUM_CH*ADDR_W-1:0] seg_max_q;

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    // Override wins when non-zero; highest set bit selects the size so a
    // malformed multi-hot override still resolves deterministically.
    function automatic logic [1:0] resolve_size(input logic [1:0] opsz,
                                                input logic [3:0] ovr);
        logic [1:0] s;
        s = opsz;
        for (int i = 0; i < 4; i++) begin
            if (ovr[i]) s = 2'(i);
        end
        return s;
    endfunction

    // A channel faults when its last touched byte lies above the limit or
    // when the access wraps past the top of the linear address space.
    function automatic logic [NUM_CH-1:0] limit_fault(
        input logic [NUM_CH*ADDR_W-1:0] addr,
        input logic [NUM_CH*2-1:0]      rw,
        input logic [NUM_CH*ADDR_W-1:0] smax,
        input logic [ADDR_W-1:0]        nbytes
    );
        logic [NUM_CH-1:0] f;
        logic [ADDR_W:0]   top;
        f = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            top = {1'b0, addr[c*ADDR_W +: ADDR_W]} + {1'b0, nbytes}
                  - (ADDR_W+1)'(1);
            if (rw[c*2 +: 2] != 2'b00) begin
                f[c] = top[ADDR_W] | (top[ADDR_W-1:0] > smax[c*ADDR_W +: ADDR_W]);
            end
        end
        return f;
    endfunction

    // ------------------------------------------------------------------
    // First beat, computed from the live inputs for use at accept
    // ------------------------------------------------------------------
    logic [1:0]               acc_size;
    logic [ADDR_W-1:0]        acc_bytes;
    logic [NUM_CH*ADDR_W-1:0] first_addr;
    logic [CNT_W-1:0]         first_iter;
    logic [NUM_CH-1:0]        first_fault;
    logic                     first_last;

    always_comb begin
        acc_size   = resolve_size(opsize, size_ovr);
        acc_bytes  = ADDR_W'(1) << acc_size;
        first_addr = ch_addr;
        if (is_push) begin
            first_addr[STK*ADDR_W +: ADDR_W] = ch_addr[STK*ADDR_W +: ADDR_W] - acc_bytes;
        end
        first_iter  = is_rep ? rep_cnt : CNT_W'(1);
        first_fault = limit_fault(first_addr, ch_rw, seg_max, acc_bytes);
        first_last  = (first_iter == CNT_W'(1)) | (|first_fault);
    end

    // ------------------------------------------------------------------
    // Following beat, stepped from the beat currently presented
    // ------------------------------------------------------------------
    logic [NUM_CH*ADDR_W-1:0] step_addr;
    logic [CNT_W-1:0]         step_iter;
    logic [NUM_CH-1:0]        step_fault;
    logic                     step_last;

    always_comb begin
        step_addr = out_addr;
        for (int c = 0; c < NUM_CH; c++) begin
            if (out_rw[c*2 +: 2] != 2'b00) begin
                step_addr[c*ADDR_W +: ADDR_W] = dir_q
                    ? out_addr[c*ADDR_W +: ADDR_W] - bytes_q
                    : out_addr[c*ADDR_W +: ADDR_W] + bytes_q;
            end
        end
        step_iter  = out_iter - CNT_W'(1);
        step_fault = limit_fault(step_addr, out_rw, seg_max_q, bytes_q);
        step_last  = (step_iter == CNT_W'(1)) | (|step_fault);
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: output / control decode
    // ------------------------------------------------------------------
    logic accept;
    logic out_hs;
    logic zero_rep;
    logic load_first;
    logic load_step;

    always_comb begin
        // A new instruction may enter only while idle and once the beat
        // register is free (empty or draining this cycle).
        in_ready   = (state_q == IDLE) & (~out_valid | out_ready) & ~flush;
        accept     = in_valid & in_ready;
        out_hs     = out_valid & out_ready;
        zero_rep   = is_rep & (rep_cnt == '0);
        // A zero-count REP is consumed without producing any beat.
        load_first = accept & ~zero_rep;
        load_step  = ~flush & out_hs & ~out_last & (state_q == RUN);
        busy       = (state_q == RUN);
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (load_first && !first_last) state_d = RUN;
            end
            RUN: begin
                if (flush)                    state_d = IDLE;
                else if (out_hs && out_last)  state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Beat register and latched context
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            out_valid <= 1'b0;
            out_addr  <= '0;
            out_rw    <= '0;
            out_size  <= '0;
            out_last  <= 1'b0;
            out_iter  <= '0;
            exc_valid <= 1'b0;
            exc_ch    <= '0;
            dir_q     <= 1'b0;
            bytes_q   <= '0;
            seg_max_q <= '0;
        end else if (flush) begin
            // Cancel wins over any accept or handshake in the same cycle.
            out_valid <= 1'b0;
            exc_valid <= 1'b0;
            exc_ch    <= '0;
        end else if (load_first) begin
            out_valid <= 1'b1;
            out_addr  <= first_addr;
            out_rw    <= ch_rw;
            out_size  <= acc_size;
            out_last  <= first_last;
            out_iter  <= first_iter;
            exc_valid <= |first_fault;
            exc_ch    <= first_fault;
            dir_q     <= dir;
            bytes_q   <= acc_bytes;
            seg_max_q <= seg_max;
        end else if (load_step) begin
            out_valid <= 1'b1;
            out_addr  <= step_addr;
            out_last  <= step_last;
            out_iter  <= step_iter;
            exc_valid <= |step_fault;
            exc_ch    <= step_fault;
        end else if (out_hs) begin
            // Final beat taken with nothing queued behind it.
            out_valid <= 1'b0;
            exc_valid <= 1'b0;
            exc_ch    <= '0;
        end
    end

endmodule

// File: tb/tb_mem_rep_agu.sv
module tb_mem_rep_agu;
  localparam int NUM_CH = 2;
  localparam int ADDR_W = 32;
  localparam int CNT_W  = 32;

  // clock / reset
  logic clk = 1'b0;
  logic clr = 1'b1;
  always #5 clk = ~clk;

  logic                     in_valid = 1'b0;
  logic                     in_ready;
  logic [1:0]               opsize   = '0;
  logic [3:0]               size_ovr = '0;
  logic                     is_rep   = 1'b0;
  logic [CNT_W-1:0]         rep_cnt  = '0;
  logic                     dir      = 1'b0;
  logic                     is_push  = 1'b0;
  logic [NUM_CH*ADDR_W-1:0] ch_addr  = '0;
  logic [NUM_CH*2-1:0]      ch_rw    = '0;
  logic [NUM_CH*ADDR_W-1:0] seg_max  = '0;
  logic                     flush    = 1'b0;
  logic                     out_valid;
  logic                     out_ready = 1'b1;
  logic [NUM_CH*ADDR_W-1:0] out_addr;
  logic [NUM_CH*2-1:0]      out_rw;
  logic [1:0]               out_size;
  logic                     out_last;
  logic [CNT_W-1:0]         out_iter;
  logic                     exc_valid;
  logic [NUM_CH-1:0]        exc_ch;
  logic                     busy;

  mem_rep_agu #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready),
    .opsize(opsize), .size_ovr(size_ovr), .is_rep(is_rep), .rep_cnt(rep_cnt),
    .dir(dir), .is_push(is_push), .ch_addr(ch_addr), .ch_rw(ch_rw),
    .seg_max(seg_max), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
    .out_rw(out_rw), .out_size(out_size), .out_last(out_last),
    .out_iter(out_iter), .exc_valid(exc_valid), .exc_ch(exc_ch), .busy(busy)
  );

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // advance one clock; outputs are sampled 1 time unit after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // present one instruction for one edge, then scramble the inputs so any
  // failure to latch them shows up in later beats
  task automatic issue(input logic [1:0] osz, input logic [3:0] ovr,
                       input logic rep, input logic [31:0] cnt,
                       input logic d, input logic push,
                       input logic [31:0] a0, input logic [31:0] a1,
                       input logic [1:0] rw0, input logic [1:0] rw1,
                       input logic [31:0] m0, input logic [31:0] m1);
    opsize   = osz;
    size_ovr = ovr;
    is_rep   = rep;
    rep_cnt  = cnt;
    dir      = d;
    is_push  = push;
    ch_addr  = {a1, a0};
    ch_rw    = {rw1, rw0};
    seg_max  = {m1, m0};
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    opsize   = 2'd3;
    size_ovr = 4'b1000;
    rep_cnt  = 32'd7;
    dir      = ~d;
    is_push  = ~push;
    ch_addr  = {2{32'hDEAD_BEEF}};
    ch_rw    = 4'b1111;
    seg_max  = '0;
  endtask

  // compare the presented beat against hand-computed values
  task automatic beat(input string tag, input logic [31:0] a0, input logic [31:0] a1,
                      input logic [31:0] iter, input logic last,
                      input logic exc, input logic [1:0] exch);
    chk({tag, ".valid"}, 64'(out_valid), 64'(1'b1));
    chk({tag, ".addr0"}, 64'(out_addr[31:0]), 64'(a0));
    chk({tag, ".addr1"}, 64'(out_addr[63:32]), 64'(a1));
    chk({tag, ".iter"}, 64'(out_iter), 64'(iter));
    chk({tag, ".last"}, 64'(out_last), 64'(last));
    chk({tag, ".exc"}, 64'(exc_valid), 64'(exc));
    chk({tag, ".exc_ch"}, 64'(exc_ch), 64'(exch));
  endtask

  initial begin
    // ---------------- reset state ----------------
    #3;
    chk("rst.valid", 64'(out_valid), 64'(1'b0));
    chk("rst.busy", 64'(busy), 64'(1'b0));
    chk("rst.addr", 64'(out_addr), 64'(0));
    chk("rst.iter", 64'(out_iter), 64'(0));
    chk("rst.exc", 64'(exc_valid), 64'(1'b0));
    chk("rst.in_ready", 64'(in_ready), 64'(1'b1));
    step();
    clr = 1'b0;
    step();

    // ---------------- 1: non-REP load ----------------
    issue(2'd2, 4'b0000, 1'b0, 32'd0, 1'b0, 1'b0, 32'h1000, 32'h5555,
          2'b01, 2'b00, 32'hFFFF, 32'h0);
    beat("t1", 32'h1000, 32'h5555, 32'd1, 1'b1, 1'b0, 2'b00);
    chk("t1.size", 64'(out_size), 64'(2'd2));
    chk("t1.rw", 64'(out_rw), 64'(4'b0001));
    chk("t1.busy", 64'(busy), 64'(1'b0));
    step();
    chk("t1.drain", 64'(out_valid), 64'(1'b0));

    // ---------------- 2: push with size override ----------------
    issue(2'd0, 4'b0010, 1'b0, 32'd0, 1'b0, 1'b1, 32'h1234, 32'h2000,
          2'b00, 2'b10, 32'h0, 32'hFFFF);
    beat("t2", 32'h1234, 32'h1FFE, 32'd1, 1'b1, 1'b0, 2'b00);
    chk("t2.size", 64'(out_size), 64'(2'd1));
    step();
    // multi-hot override resolves to its highest set bit
    issue(2'd0, 4'b0110, 1'b0, 32'd0, 1'b0, 1'b1, 32'h0, 32'h2000,
          2'b00, 2'b10, 32'h0, 32'hFFFF);
    beat("t2b", 32'h0, 32'h1FFC, 32'd1, 1'b1, 1'b0, 2'b00);
    chk("t2b.size", 64'(out_size), 64'(2'd2));
    step();

    // ---------------- 3+4: REP MOVS dir=0 with backpressure on beat 2 ----------------
    issue(2'd1, 4'b0000, 1'b1, 32'd3, 1'b0, 1'b0, 32'h100, 32'h200,
          2'b01, 2'b10, 32'hFFFF, 32'hFFFF);
    beat("t3.b1", 32'h100, 32'h200, 32'd3, 1'b0, 1'b0, 2'b00);
    chk("t3.busy", 64'(busy), 64'(1'b1));
    chk("t3.in_ready", 64'(in_ready), 64'(1'b0));
    step();
    beat("t3.b2", 32'h102, 32'h202, 32'd2, 1'b0, 1'b0, 2'b00);
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      beat("t4.hold", 32'h102, 32'h202, 32'd2, 1'b0, 1'b0, 2'b00);
    end
    out_ready = 1'b1;
    step();
    beat("t3.b3", 32'h104, 32'h204, 32'd1, 1'b1, 1'b0, 2'b00);
    chk("t3.b3.busy", 64'(busy), 64'(1'b1));
    step();
    chk("t3.end.valid", 64'(out_valid), 64'(1'b0));
    chk("t3.end.busy", 64'(busy), 64'(1'b0));

    // ---------------- 3: REP dir=1 ----------------
    issue(2'd1, 4'b0000, 1'b1, 32'd3, 1'b1, 1'b0, 32'h100, 32'h200,
          2'b01, 2'b10, 32'hFFFF, 32'hFFFF);
    beat("t3d.b1", 32'h100, 32'h200, 32'd3, 1'b0, 1'b0, 2'b00);
    step();
    beat("t3d.b2", 32'h0FE, 32'h1FE, 32'd2, 1'b0, 1'b0, 2'b00);
    step();
    beat("t3d.b3", 32'h0FC, 32'h1FC, 32'd1, 1'b1, 1'b0, 2'b00);
    step();
    chk("t3d.end", 64'(out_valid), 64'(1'b0));

    // ---------------- 5: limit fault mid-REP ----------------
    issue(2'd2, 4'b0000, 1'b1, 32'd5, 1'b0, 1'b0, 32'hFFF8, 32'h0,
          2'b01, 2'b00, 32'hFFFF, 32'h0);
    beat("t5.b1", 32'hFFF8, 32'h0, 32'd5, 1'b0, 1'b0, 2'b00);
    step();
    beat("t5.b2", 32'hFFFC, 32'h0, 32'd4, 1'b0, 1'b0, 2'b00);
    step();
    beat("t5.b3", 32'h10000, 32'h0, 32'd3, 1'b1, 1'b1, 2'b01);
    step();
    chk("t5.end.valid", 64'(out_valid), 64'(1'b0));
    chk("t5.end.busy", 64'(busy), 64'(1'b0));
    step();
    chk("t5.no_b4", 64'(out_valid), 64'(1'b0));

    // wrap past top of address space
    issue(2'd2, 4'b0000, 1'b0, 32'd0, 1'b0, 1'b0, 32'hFFFF_FFFE, 32'h0,
          2'b01, 2'b00, 32'hFFFF_FFFF, 32'h0);
    beat("t5w", 32'hFFFF_FFFE, 32'h0, 32'd1, 1'b1, 1'b1, 2'b01);
    step();
    // stack channel pre-decrement wraps below zero and faults on carry
    issue(2'd2, 4'b0000, 1'b0, 32'd0, 1'b0, 1'b1, 32'h0, 32'h2,
          2'b00, 2'b01, 32'h0, 32'hFFFF_FFFF);
    beat("t5s", 32'h0, 32'hFFFF_FFFE, 32'd1, 1'b1, 1'b1, 2'b10);
    step();

    // ---------------- 6: zero count ----------------
    issue(2'd0, 4'b0000, 1'b1, 32'd0, 1'b0, 1'b0, 32'h300, 32'h0,
          2'b01, 2'b00, 32'hFFFF, 32'h0);
    chk("t6z.valid", 64'(out_valid), 64'(1'b0));
    chk("t6z.busy", 64'(busy), 64'(1'b0));
    chk("t6z.in_ready", 64'(in_ready), 64'(1'b1));

    // flush during beat 2 of rep_cnt=4
    issue(2'd0, 4'b0000, 1'b1, 32'd4, 1'b0, 1'b0, 32'h40, 32'h80,
          2'b01, 2'b01, 32'hFFFF, 32'hFFFF);
    beat("t6f.b1", 32'h40, 32'h80, 32'd4, 1'b0, 1'b0, 2'b00);
    step();
    beat("t6f.b2", 32'h41, 32'h81, 32'd3, 1'b0, 1'b0, 2'b00);
    flush = 1'b1;
    #1;
    chk("t6f.in_ready", 64'(in_ready), 64'(1'b0));
    step();
    flush = 1'b0;
    chk("t6f.valid", 64'(out_valid), 64'(1'b0));
    chk("t6f.busy", 64'(busy), 64'(1'b0));
    step();
    chk("t6f.quiet", 64'(out_valid), 64'(1'b0));
    chk("t6f.ready_again", 64'(in_ready), 64'(1'b1));

    // flush overrides a simultaneous accept
    opsize   = 2'd0;
    size_ovr = 4'b0000;
    is_rep   = 1'b0;
    is_push  = 1'b0;
    ch_addr  = {32'h0, 32'h500};
    ch_rw    = 4'b0001;
    seg_max  = {32'h0, 32'hFFFF};
    in_valid = 1'b1;
    flush    = 1'b1;
    #1;
    chk("t6o.in_ready", 64'(in_ready), 64'(1'b0));
    step();
    in_valid = 1'b0;
    flush    = 1'b0;
    chk("t6o.valid", 64'(out_valid), 64'(1'b0));

    // back-to-back single beats: accept while the previous beat drains
    issue(2'd0, 4'b0000, 1'b0, 32'd0, 1'b0, 1'b0, 32'h600, 32'h0,
          2'b01, 2'b00, 32'hFFFF, 32'h0);
    beat("t6bb.a", 32'h600, 32'h0, 32'd1, 1'b1, 1'b0, 2'b00);
    chk("t6bb.in_ready", 64'(in_ready), 64'(1'b1));
    issue(2'd3, 4'b0000, 1'b0, 32'd0, 1'b0, 1'b0, 32'h700, 32'h0,
          2'b10, 2'b00, 32'hFFFF, 32'h0);
    beat("t6bb.b", 32'h700, 32'h0, 32'd1, 1'b1, 1'b0, 2'b00);
    chk("t6bb.size", 64'(out_size), 64'(2'd3));
    step();

    // asynchronous reset mid-sequence
    issue(2'd1, 4'b0000, 1'b1, 32'd3, 1'b0, 1'b0, 32'h100, 32'h200,
          2'b01, 2'b10, 32'hFFFF, 32'hFFFF);
    beat("t6r.b1", 32'h100, 32'h200, 32'd3, 1'b0, 1'b0, 2'b00);
    #2;
    clr = 1'b1;
    #1;
    chk("t6r.valid", 64'(out_valid), 64'(1'b0));
    chk("t6r.busy", 64'(busy), 64'(1'b0));
    chk("t6r.addr", 64'(out_addr), 64'(0));
    chk("t6r.iter", 64'(out_iter), 64'(0));
    step();
    clr = 1'b0;
    step();
    chk("t6r.after", 64'(out_valid), 64'(1'b0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/mem_rep_agu.md
Name: mem_rep_agu

Overview:
Memory-stage address sequencer for the M stage. It is a parametrised successor to the single-shot memory address path and adds the following:
- resolves the effective access size from opsize and the size override
- applies the push pre-decrement on the stack channel
- walks REP string iterations one beat per cycle across NUM_CH memory channels
- checks each beat against the segment limits
It sits between RRAG/M-stage operand latch and the d$ request port, and emits one registered access beat per cycle under a valid/ready handshake.

Parameters:
NUM_CH, 2, number of memory operand channels; channel NUM_CH-1 is the stack channel.
ADDR_W, 32, linear address width.
CNT_W, 32, REP count width.

Ports:
clk  in  1  stage clock
clr  in  1  asynchronous active-high reset
in_valid  in  1  instruction presented
in_ready  out  1  block accepts instruction this cycle
opsize  in  2  normal operand size (0=1B,1=2B,2=4B,3=8B)
size_ovr  in  4  one-hot size override; 0 = use opsize
is_rep  in  1  instruction is REP-prefixed string op
rep_cnt  in  CNT_W  iteration count (ECX)
dir  in  1  direction flag; 1 = decrement addresses
is_push  in  1  push-class op; pre-decrement stack channel
ch_addr  in  NUM_CH*ADDR_W  start address per channel
ch_rw  in  NUM_CH*2  per-channel access type; 00 = no access
seg_max  in  NUM_CH*ADDR_W  highest legal byte address per channel
flush  in  1  synchronous cancel (branch/exception recovery)
out_valid  out  1  beat valid
out_ready  in  1  downstream (d$) accepts beat
out_addr  out  NUM_CH*ADDR_W  beat address per channel
out_rw  out  NUM_CH*2  latched ch_rw
out_size  out  2  resolved size
out_last  out  1  final beat of instruction
out_iter  out  CNT_W  remaining iterations including this beat
exc_valid  out  1  beat carries segment-limit exception
exc_ch  out  NUM_CH  per-channel fault mask
busy  out  1  REP sequence in progress

Behaviour:
- Reset (clr=1, asynchronous): state=IDLE and all outputs 0, except in_ready, which follows its equation. Reset mid-sequence abandons the sequence with no further beats.
- Size resolution:
  - If size_ovr==0, size = opsize.
  - Otherwise size = index of the highest set bit of size_ovr.
  - bytes = 1<<size.
- States are IDLE and RUN.
- in_ready = (state==IDLE) & (~out_valid | out_ready) & ~flush.
- Accept happens when in_valid & in_ready. All inputs are latched at accept; later input changes are ignored until the next accept.
- Accept with is_rep=1 and rep_cnt=0: no beat is emitted, the block stays IDLE, and the instruction is consumed.
- Accept otherwise: the first beat is registered and out_valid=1 the next cycle (latency 1).
  - out_iter = rep_cnt if is_rep, else 1.
  - out_last = (out_iter==1).
  - If is_push, the stack channel address = ch_addr - bytes (first beat only).
  - If the beat is not last, state goes to RUN and busy=1.
- In RUN, on each out_ready with out_valid:
  - each channel with rw!=00 advances by +bytes (dir=0) or -bytes (dir=1), modulo 2^ADDR_W
  - channels with rw=00 hold their address
  - out_iter decrements by 1
  - the next beat is valid in the following cycle
- When a beat with out_last handshakes, state goes to IDLE and busy=0.
- out_valid=1 with out_ready=0: all out_* hold stable and no state advances.
- Limit check, for each access channel of every beat: fault if addr+bytes-1 > seg_max, or if that sum carries out of ADDR_W.
  - A faulting beat is emitted with exc_valid=1, the faulting channel bits set in exc_ch, and out_last forced to 1.
  - The remaining iterations are cancelled and state returns to IDLE after the handshake.
- exc_valid and exc_ch are registered with the beat and are 0 on non-faulting beats.
- flush=1: next cycle out_valid=0, state=IDLE, busy=0. flush overrides a simultaneous accept or handshake.
- Only the push pre-decrement applies to the stack channel; REP stepping applies to all access channels uniformly.

Test Plan:
1. Non-REP load: opsize=2, ch_addr0=0x1000, ch_rw0=01, ch_rw1=00, seg_max0=0xFFFF → one beat next cycle with out_addr0=0x1000, out_size=2, out_last=1, out_iter=1, exc_valid=0.
2. Push: size_ovr=4'b0010, is_push=1, ch_addr1=0x2000, rw1=10 → out_size=1, out_addr1=0x1FFE.
3. REP MOVS: rep_cnt=3, opsize=1, dir=0, ch0=0x100, ch1=0x200, both accessing → beats (0x100,0x200), (0x102,0x202), (0x104,0x204); out_iter 3,2,1; last on beat 3. With dir=1 the beats are 0x100, 0xFE, 0xFC.
4. Backpressure: during test 3, hold out_ready=0 for 4 cycles on beat 2 → beat 2 is stable for all 4 cycles and 3 beats total are emitted.
5. Limit fault: rep_cnt=5, opsize=2, ch0=0xFFF8, seg_max0=0xFFFF → beat 1 is clean; beat 2 (0xFFFC..0xFFFF) is clean; beat 3 at 0x10000 has exc_valid=1, exc_ch=01, out_last=1; no 4th beat. A separate run with ch0=0xFFFFFFFE, size 2 faults on wrap.
6. Zero count, flush, and reset: rep_cnt=0 REP → no beat and in_ready is high the next cycle. A flush during beat 2 of rep_cnt=4 → out_valid=0 next cycle and busy=0. clr asserted mid-sequence → outputs 0 immediately (asynchronously).
